baud_frac_gen: RTL

- Runtime-programmable baud/oversample tick generator for the debug UART. Successor to the compile-time baud divisor helpers.
- Fractional divider: effective period is DIV_INT + DIV_FRAC/2^FRAC_W clocks per oversample tick.
- Outputs oversample, mid-bit and bit-boundary strobes for the UART rx/tx paths.
- Supports rx phase resync on start-bit detection, and divisor reprogramming that takes effect only at a bit boundary.

---
 rtl/baud_pkg.sv | 64 ++++++
 rtl/baud_frac_div.sv | 59 +++++
 rtl/baud_frac_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// -----------------------------------------------------------------------------
// baud_pkg
// Shared constants, divisor type and reset-divisor helpers for the debug UART
// baud generator.
//   OVSAMP_DEF           default oversample ticks per bit
//   BAUD_DIV_W/FRAC_W    default integer / fractional divisor widths
//   baud_div_t           {integer, fraction} divisor at the default widths
//   baud_div_int()       integer clocks per oversample tick
//   baud_div_frac()      rounded fractional part, units of 2^-frac_w
// -----------------------------------------------------------------------------
package baud_pkg;

    localparam int unsigned OVSAMP_DEF  = 32'd8;
    localparam int unsigned BAUD_DIV_W  = 32'd16;
    localparam int unsigned BAUD_FRAC_W = 32'd4;

    typedef struct packed {
        logic [BAUD_DIV_W-1:0]  div_int;
        logic [BAUD_FRAC_W-1:0] div_frac;
    } baud_div_t;

    // Integer part of hz/(ovs*baud). A clock that is not faster than the
    // oversample rate yields 0, which the generator clamps to its minimum.
    function automatic int unsigned baud_div_int(
        input int unsigned hz,
        input int unsigned baud,
        input int unsigned ovs
    );
        longint unsigned den;
        den = 64'(ovs) * 64'(baud);
        if ((den == 64'd0) || (64'(hz) <= den)) begin
            return 32'd0;
        end else begin
            return 32'(64'(hz) / den);
        end
    endfunction

    // Rounded remainder scaled to 2^frac_w. Saturates instead of rolling over
    // so a round-up never turns into a zero fraction.
    function automatic int unsigned baud_div_frac(
        input int unsigned hz,
        input int unsigned baud,
        input int unsigned ovs,
        input int unsigned frac_w
    );
        longint unsigned den;
        longint unsigned rem;
        longint unsigned q;
        den = 64'(ovs) * 64'(baud);
        if ((den == 64'd0) || (64'(hz) <= den)) begin
            return 32'd0;
        end else begin
            rem = 64'(hz) % den;
            q   = ((rem << frac_w) + (den >> 1)) / den;
            if (q >= (64'd1 << frac_w)) begin
                q = (64'd1 << frac_w) - 64'd1;
            end else begin
                q = q;
            end
            return 32'(q);
        end
    endfunction

endpackage

// File: rtl/baud_frac_div.sv
// -----------------------------------------------------------------------------
// baud_frac_div
// Fractional clock divider: a down-counter reloaded with div_int-1 (+1 when
// the fractional accumulator overflows) producing one raw oversample tick
// per period.
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       low holds the counter in the restart state
//   sync         restart phase this cycle; suppresses a coincident tick
//   div_int      integer divisor (>= 2, guaranteed by the caller)
//   div_frac     fractional divisor, units of 2^-FRAC_W
//   tick         raw combinational tick, one cycle
// -----------------------------------------------------------------------------
module baud_frac_div #(
    parameter int unsigned       DIV_W   = 32'd16,
    parameter int unsigned       FRAC_W  = 32'd4,
    parameter logic [DIV_W-1:0]  RST_INT = DIV_W'(32'd2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sync,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick
);

    logic [DIV_W-1:0]  cnt_r;
    logic [FRAC_W-1:0] acc_r;
    logic [FRAC_W:0]   sum_s;
    logic              carry_s;
    logic              tick_s;

    // Fraction accumulate and tick decode; the overflow stretches the next period by one clock
    always_comb begin
        sum_s   = {1'b0, acc_r} + {1'b0, div_frac};
        carry_s = sum_s[FRAC_W];
        tick_s  = enable && !sync && (cnt_r == {DIV_W{1'b0}});
    end

    assign tick = tick_s;

    // Period counter and fractional accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= RST_INT - DIV_W'(32'd1);
            acc_r <= {FRAC_W{1'b0}};
        end else if (!enable || sync) begin
            cnt_r <= div_int - DIV_W'(32'd1);
            acc_r <= {FRAC_W{1'b0}};
        end else if (cnt_r == {DIV_W{1'b0}}) begin
            cnt_r <= div_int - DIV_W'(32'd1) + DIV_W'(carry_s);
            acc_r <= sum_s[FRAC_W-1:0];
        end else begin
            cnt_r <= cnt_r - DIV_W'(32'd1);
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/baud_frac_gen.sv
// -----------------------------------------------------------------------------
// baud_frac_gen
// Runtime-programmable oversample / mid-bit / bit-boundary strobe generator
// for the debug UART.
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   enable_i            run; low restarts counters and applies a pending divisor
//   rx_sync_i           one-cycle start-bit resync pulse
//   cfg_we_i            load cfg_div_int_i / cfg_div_frac_i into pending
//   cfg_pending_o       pending divisor not yet applied
//   cfg_err_o           last applied divisor was below 2 and was clamped
//   ovs_tick_o          oversample strobe
//   mid_tick_o          bit-centre strobe
//   baud_tick_o         bit-boundary strobe (divisor apply point)
// -----------------------------------------------------------------------------
module baud_frac_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_RATE  = 32'd25_000_000,
    parameter int unsigned BAUD_RATE = 32'd115_200,
    parameter int unsigned OVSAMP    = OVSAMP_DEF,
    parameter int unsigned DIV_W     = BAUD_DIV_W,
    parameter int unsigned FRAC_W    = BAUD_FRAC_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              rx_sync_i,
    input  logic              cfg_we_i,
    input  logic [DIV_W-1:0]  cfg_div_int_i,
    input  logic [FRAC_W-1:0] cfg_div_frac_i,
    output logic              cfg_pending_o,
    output logic              cfg_err_o,
    output logic              ovs_tick_o,
    output logic              mid_tick_o,
    output logic              baud_tick_o
);

    localparam int unsigned PH_W         = $clog2(OVSAMP);
    localparam int unsigned RST_INT_RAW  = baud_div_int(CLK_RATE, BAUD_RATE, OVSAMP);
    localparam int unsigned RST_FRAC_RAW = baud_div_frac(CLK_RATE, BAUD_RATE, OVSAMP, FRAC_W);
    localparam logic        RST_CLAMP    = (RST_INT_RAW < 32'd2) ||
                                           (64'(RST_INT_RAW) >= (64'd1 << DIV_W));
    localparam logic [DIV_W-1:0]  RST_INT  = RST_CLAMP ? DIV_W'(32'd2) : DIV_W'(RST_INT_RAW);
    localparam logic [FRAC_W-1:0] RST_FRAC = RST_CLAMP ? {FRAC_W{1'b0}} : FRAC_W'(RST_FRAC_RAW);

    logic [DIV_W-1:0]  pend_int_r;
    logic [FRAC_W-1:0] pend_frac_r;
    logic              pend_r;
    logic [DIV_W-1:0]  act_int_r;
    logic [FRAC_W-1:0] act_frac_r;
    logic              err_r;
    logic [PH_W-1:0]   phase_r;
    logic              ovs_r;
    logic              mid_r;
    logic              baud_r;

    logic              raw_tick_s;
    logic              raw_mid_s;
    logic              raw_baud_s;
    logic              apply_s;
    logic              clamp_s;
    logic [DIV_W-1:0]  new_int_s;
    logic [FRAC_W-1:0] new_frac_s;

    baud_frac_div #(
        .DIV_W   (DIV_W),
        .FRAC_W  (FRAC_W),
        .RST_INT (RST_INT)
    ) u_div (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .enable   (enable_i),
        .sync     (rx_sync_i),
        .div_int  (act_int_r),
        .div_frac (act_frac_r),
        .tick     (raw_tick_s)
    );

    // Strobe decode, apply point and divisor clamp
    always_comb begin
        raw_mid_s  = raw_tick_s && (phase_r == PH_W'(OVSAMP / 32'd2 - 32'd1));
        raw_baud_s = raw_tick_s && (phase_r == PH_W'(OVSAMP - 32'd1));
        // Applying only at a bit boundary (or while idle) keeps a frame's bits equal length
        apply_s    = pend_r && (raw_baud_s || !enable_i);
        clamp_s    = (pend_int_r < DIV_W'(32'd2));
        if (clamp_s) begin
            new_int_s  = DIV_W'(32'd2);
            new_frac_s = {FRAC_W{1'b0}};
        end else begin
            new_int_s  = pend_int_r;
            new_frac_s = pend_frac_r;
        end
    end

    // Pending divisor: a write always wins, so a write on the apply edge stays pending
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_int_r  <= RST_INT;
            pend_frac_r <= RST_FRAC;
            pend_r      <= 1'b0;
        end else if (cfg_we_i) begin
            pend_int_r  <= cfg_div_int_i;
            pend_frac_r <= cfg_div_frac_i;
            pend_r      <= 1'b1;
        end else if (apply_s) begin
            pend_int_r  <= pend_int_r;
            pend_frac_r <= pend_frac_r;
            pend_r      <= 1'b0;
        end else begin
            pend_int_r  <= pend_int_r;
            pend_frac_r <= pend_frac_r;
            pend_r      <= pend_r;
        end
    end

    // Active divisor and clamp flag; the divider picks it up at its next reload
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_int_r  <= RST_INT;
            act_frac_r <= RST_FRAC;
            err_r      <= 1'b0;
        end else if (apply_s) begin
            act_int_r  <= new_int_s;
            act_frac_r <= new_frac_s;
            err_r      <= clamp_s;
        end else begin
            act_int_r  <= act_int_r;
            act_frac_r <= act_frac_r;
            err_r      <= err_r;
        end
    end

    // Phase counter and registered strobes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_r <= {PH_W{1'b0}};
            ovs_r   <= 1'b0;
            mid_r   <= 1'b0;
            baud_r  <= 1'b0;
        end else if (!enable_i || rx_sync_i) begin
            phase_r <= {PH_W{1'b0}};
            ovs_r   <= 1'b0;
            mid_r   <= 1'b0;
            baud_r  <= 1'b0;
        end else if (raw_tick_s) begin
            // OVSAMP is a power of two, so the increment wraps to 0 by itself
            phase_r <= phase_r + PH_W'(32'd1);
            ovs_r   <= 1'b1;
            mid_r   <= raw_mid_s;
            baud_r  <= raw_baud_s;
        end else begin
            phase_r <= phase_r;
            ovs_r   <= 1'b0;
            mid_r   <= 1'b0;
            baud_r  <= 1'b0;
        end
    end

    assign cfg_pending_o = pend_r;
    assign cfg_err_o     = err_r;
    assign ovs_tick_o    = ovs_r;
    assign mid_tick_o    = mid_r;
    assign baud_tick_o   = baud_r;

endmodule
